// File: rtl/md_ctrl.sv
// Multiply/divide sequencer for the E stage: times multi-cycle mult/div ops,
// owns HI/LO and requests a D-stage stall while an operation is in flight.
module md_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [2:0]  md_op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        flush,
    input  logic        md_use_d,
    output logic        start,
    output logic        busy,
    output logic        stall,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    typedef enum logic {IDLE, RUN} state_t;

    state_t      state, state_nxt;
    logic [4:0]  count, count_nxt;
    logic [31:0] hi_nxt, lo_nxt;
    logic [31:0] res_hi, res_lo, res_hi_nxt, res_lo_nxt;
    logic        res_wr, res_wr_nxt;
    logic [64:0] result;
    logic        done;

    // Returns {write_enable, hi, lo}; write_enable is 0 for a divide by zero.
    function automatic logic [64:0] md_result(input logic [2:0] op,
                                              input logic [31:0] a,
                                              input logic [31:0] b);
        logic signed [63:0] sa, sb;
        logic signed [31:0] qa, qb;
        md_result = '0;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        qa = a;
        qb = b;
        case (op)
            OP_MULT:  md_result = {1'b1, 64'(sa * sb)};
            OP_MULTU: md_result = {1'b1, 64'({32'd0, a} * {32'd0, b})};
            OP_DIV: begin
                if (b == 32'd0)
                    md_result = '0;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
                    md_result = {1'b1, 32'd0, 32'h8000_0000};
                else
                    md_result = {1'b1, 32'(qa % qb), 32'(qa / qb)};
            end
            OP_DIVU: begin
                if (b != 32'd0)
                    md_result = {1'b1, a % b, a / b};
            end
            default: md_result = '0;
        endcase
    endfunction

    assign busy   = (state == RUN);
    assign start  = (md_op >= OP_MULT) && (md_op <= OP_DIVU) && !flush && !busy;
    assign stall  = md_use_d && (start || busy);
    assign result = md_result(md_op, rs_val, rt_val);
    assign done   = busy && (count == 5'd1);

    always_comb begin
        state_nxt  = state;
        count_nxt  = count;
        hi_nxt     = hi;
        lo_nxt     = lo;
        res_hi_nxt = res_hi;
        res_lo_nxt = res_lo;
        res_wr_nxt = res_wr;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt  = RUN;
                    count_nxt  = (md_op == OP_MULT || md_op == OP_MULTU) ?
                                 5'(MULT_CYCLES) : 5'(DIV_CYCLES);
                    res_wr_nxt = result[64];
                    res_hi_nxt = result[63:32];
                    res_lo_nxt = result[31:0];
                end
            end
            RUN: begin
                count_nxt = count - 5'd1;
                if (done) begin
                    state_nxt = IDLE;
                    if (res_wr) begin
                        hi_nxt = res_hi;
                        lo_nxt = res_lo;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
        // Direct moves land when idle, and override a result completing this edge.
        if (!flush && (!busy || done)) begin
            if (md_op == OP_MTHI) hi_nxt = rs_val;
            if (md_op == OP_MTLO) lo_nxt = rs_val;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state  <= IDLE;
            count  <= '0;
            hi     <= '0;
            lo     <= '0;
            res_hi <= '0;
            res_lo <= '0;
            res_wr <= 1'b0;
        end else begin
            state  <= state_nxt;
            count  <= count_nxt;
            hi     <= hi_nxt;
            lo     <= lo_nxt;
            res_hi <= res_hi_nxt;
            res_lo <= res_lo_nxt;
            res_wr <= res_wr_nxt;
        end
    end

endmodule

// File: tb/tb_md_ctrl.sv
// Bench for md_ctrl: directed scenarios followed by random op streams, all
// compared each cycle against a cycle-indexed behavioural model of HI/LO.
module tb_md_ctrl;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    logic        clk;
    logic        reset_n;
    logic [2:0]  md_op;
    logic [31:0] rs_val, rt_val;
    logic        flush, md_use_d;
    logic        start, busy, stall;
    logic [31:0] hi, lo;

    md_ctrl #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
        .clk(clk), .reset_n(reset_n), .md_op(md_op), .rs_val(rs_val),
        .rt_val(rt_val), .flush(flush), .md_use_d(md_use_d), .start(start),
        .busy(busy), .stall(stall), .hi(hi), .lo(lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Model: HI/LO plus the cycle an operation was issued and its pending result.
    logic [31:0] m_hi, m_lo, p_hi, p_lo;
    logic        p_wr;
    int          cyc, t_issue, p_n;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_result(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint          sp;
        longint unsigned up;
        int              sa, sb;
        p_wr = 1'b1;
        sa = int'(a);
        sb = int'(b);
        case (op)
            3'd1: begin sp = longint'(sa) * longint'(sb); {p_hi, p_lo} = 64'(sp); p_n = MULT_N; end
            3'd2: begin up = 64'(a) * 64'(b); {p_hi, p_lo} = up; p_n = MULT_N; end
            3'd3: begin
                p_n = DIV_N;
                if (b == 0) p_wr = 1'b0;
                else if (a == 32'h8000_0000 && sb == -1) begin p_hi = 0; p_lo = 32'h8000_0000; end
                else begin p_lo = 32'(sa / sb); p_hi = 32'(sa % sb); end
            end
            default: begin
                p_n = DIV_N;
                if (b == 0) p_wr = 1'b0;
                else begin p_lo = a / b; p_hi = a % b; end
            end
        endcase
    endtask

    // Apply inputs for one cycle, check mid-cycle, then advance the model across the edge.
    task automatic drive(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic fl, input logic use_d, input logic rn);
        logic m_busy, e_start, completing;
        md_op = op; rs_val = a; rt_val = b; flush = fl; md_use_d = use_d; reset_n = rn;
        @(negedge clk);
        m_busy     = (cyc > t_issue) && (cyc <= t_issue + p_n);
        completing = m_busy && (cyc == t_issue + p_n);
        e_start    = (op >= 1) && (op <= 4) && !fl && !m_busy;
        check("start", 32'(start), 32'(e_start));
        check("busy",  32'(busy),  32'(m_busy));
        check("stall", 32'(stall), 32'(use_d && (e_start || m_busy)));
        check("hi", hi, m_hi);
        check("lo", lo, m_lo);
        if (!rn) begin
            m_hi = 0; m_lo = 0; t_issue = -1000; p_n = 0;
        end else begin
            if (completing && p_wr) begin m_hi = p_hi; m_lo = p_lo; end
            if (e_start) begin model_result(op, a, b); t_issue = cyc; end
            if (!fl && (!m_busy || completing)) begin
                if (op == 3'd5) m_hi = a;
                if (op == 3'd6) m_lo = a;
            end
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input logic use_d);
        for (int i = 0; i < n; i++) drive(3'd0, 32'd0, 32'd0, 1'b0, use_d, 1'b1);
    endtask

    initial begin
        logic [2:0] op;
        logic       m_b;
        md_op = 0; rs_val = 0; rt_val = 0; flush = 0; md_use_d = 0; reset_n = 0;
        m_hi = 0; m_lo = 0; p_hi = 0; p_lo = 0; p_wr = 0; p_n = 0;
        cyc = 0; t_issue = -1000;
        repeat (2) @(posedge clk);
        #1;
        drive(3'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);

        // mult / multu of 0xFFFFFFFF by 2
        drive(3'd1, 32'hFFFF_FFFF, 32'd2, 1'b0, 1'b0, 1'b1);
        idle(MULT_N, 1'b0);
        check("mult_hi", hi, 32'hFFFF_FFFF);
        check("mult_lo", lo, 32'hFFFF_FFFE);
        drive(3'd2, 32'hFFFF_FFFF, 32'd2, 1'b0, 1'b0, 1'b1);
        idle(MULT_N, 1'b0);
        check("multu_hi", hi, 32'h1);
        check("multu_lo", lo, 32'hFFFF_FFFE);

        // signed divide and the overflow case
        drive(3'd3, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0, 1'b1);
        idle(DIV_N, 1'b0);
        check("div_hi", hi, 32'hFFFF_FFFF);
        check("div_lo", lo, 32'hFFFF_FFFD);
        drive(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1);
        idle(DIV_N, 1'b0);
        check("ovf_hi", hi, 32'h0);
        check("ovf_lo", lo, 32'h8000_0000);

        // divu by zero keeps HI/LO; stall tracks busy
        drive(3'd5, 32'h11, 32'd0, 1'b0, 1'b0, 1'b1);
        drive(3'd6, 32'h22, 32'd0, 1'b0, 1'b0, 1'b1);
        drive(3'd4, 32'h1234, 32'd0, 1'b0, 1'b1, 1'b1);
        idle(DIV_N + 2, 1'b1);
        check("dz_hi", hi, 32'h11);
        check("dz_lo", lo, 32'h22);

        // flushed ops have no effect
        drive(3'd1, 32'd3, 32'd4, 1'b1, 1'b1, 1'b1);
        drive(3'd5, 32'hABCD, 32'd0, 1'b1, 1'b0, 1'b1);
        idle(2, 1'b0);
        check("flush_hi", hi, 32'h11);

        // reset on the third busy cycle of a divide, then mtlo
        drive(3'd3, 32'd100, 32'd7, 1'b0, 1'b0, 1'b1);
        idle(2, 1'b0);
        drive(3'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
        drive(3'd6, 32'h5, 32'd0, 1'b0, 1'b0, 1'b1);
        check("rst_hi", hi, 32'h0);
        check("mtlo_lo", lo, 32'h5);
        idle(DIV_N, 1'b0);

        // random streams; direct moves are only issued when idle
        for (int i = 0; i < 600; i++) begin
            m_b = (cyc > t_issue) && (cyc <= t_issue + p_n);
            op = 3'($urandom_range(0, 7));
            if (m_b && (op == 3'd5 || op == 3'd6)) op = 3'd0;
            drive(op,
                  ($urandom_range(0, 3) == 0) ? 32'h8000_0000 : $urandom,
                  ($urandom_range(0, 5) == 0) ? 32'($urandom_range(0, 1)) - 32'd1 + 32'($urandom_range(0, 1)) : $urandom,
                  ($urandom_range(0, 7) == 0),
                  1'($urandom),
                  ($urandom_range(0, 63) != 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
